// File: rtl/branch_commit_unit.sv
// Branch commit unit: carries IF prediction metadata (PC, BTB hit) through
// ID and EX, resolves conditional branches / JAL / JALR in EX, and registers
// the BTB commit bundle in EX/MEM.
// Optional build macro BR_PERF_CNT_EN adds saturating committed-branch and
// misprediction counters (perf_br_cnt_o, perf_mispred_cnt_o).
module branch_commit_unit #(
    parameter int INDEX_WIDTH = 12
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          IF_valid_i,
    input  logic [31:0]                   IF_pc_i,
    input  logic                          IF_btb_hit_i,
    input  logic                          stall_i,
    input  logic                          flush_i,
    input  logic                          ID_is_br_i,
    input  logic                          ID_is_jal_i,
    input  logic                          ID_is_jalr_i,
    input  logic [2:0]                    ID_funct3_i,
    input  logic [31:0]                   EX_rs1_i,
    input  logic [31:0]                   EX_rs2_i,
    input  logic [31:0]                   EX_imm_i,
    output logic [INDEX_WIDTH-1:0]        EXMEM_btb_wr_index_o,
    output logic [32-INDEX_WIDTH-2-1:0]   EXMEM_btb_wr_tag_o,
    output logic [31:0]                   EXMEM_btb_wr_target_o,
    output logic                          EXMEM_btb_hit_o,
    output logic                          EXMEM_br_decision_o,
    output logic                          EXMEM_is_jmp_o,
    output logic [31:0]                   EXMEM_pc_plus4_o
`ifdef BR_PERF_CNT_EN
    ,
    output logic [31:0]                   perf_br_cnt_o,
    output logic [31:0]                   perf_mispred_cnt_o
`endif
);

    localparam int TAG_WIDTH = 32 - INDEX_WIDTH - 2;

    // Branch condition; funct3 010/011 are never taken (and never committed).
    function automatic logic br_taken(input logic [2:0] f3,
                                      input logic signed [31:0] a,
                                      input logic signed [31:0] b);
        logic r;
        r = 1'b0;
        case (f3)
            3'b000:  r = (a == b);
            3'b001:  r = (a != b);
            3'b100:  r = (a < b);
            3'b101:  r = (a >= b);
            3'b110:  r = ($unsigned(a) <  $unsigned(b));
            3'b111:  r = ($unsigned(a) >= $unsigned(b));
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    function automatic logic br_legal(input logic [2:0] f3);
        return (f3 != 3'b010) && (f3 != 3'b011);
    endfunction

    // IF/ID stage
    logic        vld_p0;
    logic [31:0] pc_p0;
    logic        hit_p0;

    // ID/EX stage
    logic        vld_p1;
    logic [31:0] pc_p1;
    logic        hit_p1;
    logic        is_br_p1;
    logic        is_jal_p1;
    logic        is_jalr_p1;
    logic [2:0]  funct3_p1;

    // EX/MEM stage (commit bundle)
    logic                   jmp_p2;
    logic                   dec_p2;
    logic                   hit_p2;
    logic [INDEX_WIDTH-1:0] index_p2;
    logic [TAG_WIDTH-1:0]   tag_p2;
    logic [31:0]            target_p2;
    logic [31:0]            pc4_p2;

    // EX resolution
    logic signed [31:0] rs1_s;
    logic signed [31:0] rs2_s;
    logic        legal_ex;
    logic        jmp_ex;
    logic        taken_ex;
    logic [31:0] pc_imm_ex;
    logic [31:0] rs1_imm_ex;
    logic [31:0] target_ex;

    assign rs1_s = EX_rs1_i;
    assign rs2_s = EX_rs2_i;

    // Resolve the instruction held in ID/EX: commit qualifier, decision, target.
    always_comb begin
        legal_ex   = br_legal(funct3_p1);
        jmp_ex     = vld_p1 & ((is_br_p1 & legal_ex) | is_jal_p1 | is_jalr_p1);
        pc_imm_ex  = pc_p1 + EX_imm_i;
        rs1_imm_ex = EX_rs1_i + EX_imm_i;
        target_ex  = is_jalr_p1 ? (rs1_imm_ex & 32'hFFFF_FFFE) : pc_imm_ex;
        taken_ex   = jmp_ex & (is_jal_p1 | is_jalr_p1 | br_taken(funct3_p1, rs1_s, rs2_s));
    end

    // IF/ID and ID/EX payload: held on stall, meaningless while the valid bit is low.
    always_ff @(posedge clk_i) begin
        if (!stall_i) begin
            pc_p0      <= IF_pc_i;
            hit_p0     <= IF_btb_hit_i;
            pc_p1      <= pc_p0;
            hit_p1     <= hit_p0;
            is_br_p1   <= ID_is_br_i;
            is_jal_p1  <= ID_is_jal_i;
            is_jalr_p1 <= ID_is_jalr_i;
            funct3_p1  <= ID_funct3_i;
        end
    end

    // Valid bits and commit bundle: flush beats stall beats advance; reset clears the outputs.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            vld_p0    <= 1'b0;
            vld_p1    <= 1'b0;
            jmp_p2    <= 1'b0;
            dec_p2    <= 1'b0;
            hit_p2    <= 1'b0;
            index_p2  <= '0;
            tag_p2    <= '0;
            target_p2 <= '0;
            pc4_p2    <= '0;
        end else begin
            if (flush_i) begin
                vld_p0 <= 1'b0;
                vld_p1 <= 1'b0;
                jmp_p2 <= 1'b0;
                dec_p2 <= 1'b0;
            end else if (!stall_i) begin
                vld_p0 <= IF_valid_i;
                vld_p1 <= vld_p0;
                jmp_p2 <= jmp_ex;
                dec_p2 <= taken_ex;
            end
            if (!stall_i) begin
                hit_p2    <= hit_p1;
                index_p2  <= pc_p1[INDEX_WIDTH+1:2];
                tag_p2    <= pc_p1[31:INDEX_WIDTH+2];
                target_p2 <= target_ex;
                pc4_p2    <= pc_p1 + 32'd4;
            end
        end
    end

    assign EXMEM_btb_wr_index_o  = index_p2;
    assign EXMEM_btb_wr_tag_o    = tag_p2;
    assign EXMEM_btb_wr_target_o = target_p2;
    assign EXMEM_btb_hit_o       = hit_p2;
    assign EXMEM_br_decision_o   = dec_p2;
    assign EXMEM_is_jmp_o        = jmp_p2;
    assign EXMEM_pc_plus4_o      = pc4_p2;

`ifdef BR_PERF_CNT_EN
    function automatic logic [31:0] sat_inc(input logic [31:0] c);
        return (c == 32'hFFFF_FFFF) ? c : c + 32'd1;
    endfunction

    logic [31:0] br_cnt;
    logic [31:0] mispred_cnt;

    // Count each commit once, on the edge where it leaves EX/MEM (never while stalled).
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            br_cnt      <= '0;
            mispred_cnt <= '0;
        end else if (!stall_i && jmp_p2) begin
            br_cnt <= sat_inc(br_cnt);
            if (hit_p2 != dec_p2)
                mispred_cnt <= sat_inc(mispred_cnt);
        end
    end

    assign perf_br_cnt_o      = br_cnt;
    assign perf_mispred_cnt_o = mispred_cnt;
`endif

endmodule

// File: tb/tb_branch_commit_unit.sv
// Scoreboard bench for branch_commit_unit: a shadow pipeline feeds IF/ID/EX
// inputs per cycle, pushes hand-computed expected commits, and a monitor
// pops/compares each fresh commit seen on EXMEM_*.
module tb_branch_commit_unit;

    typedef struct {
        logic        v;
        logic [31:0] pc;
        logic        hit;
        logic        br, jal, jalr;
        logic [2:0]  f3;
        logic [31:0] rs1, rs2, imm;
        logic        exp_jmp;
        logic        exp_dec;
        logic [31:0] exp_tgt;
    } instr_t;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        IF_valid_i;
    logic [31:0] IF_pc_i;
    logic        IF_btb_hit_i;
    logic        stall_i;
    logic        flush_i;
    logic        ID_is_br_i, ID_is_jal_i, ID_is_jalr_i;
    logic [2:0]  ID_funct3_i;
    logic [31:0] EX_rs1_i, EX_rs2_i, EX_imm_i;
    logic [11:0] wr_index;
    logic [17:0] wr_tag;
    logic [31:0] wr_target;
    logic        btb_hit, br_dec, is_jmp;
    logic [31:0] pc_plus4;
`ifdef BR_PERF_CNT_EN
    logic [31:0] perf_br_cnt, perf_mispred_cnt;
`endif

    int checks = 0;
    int failures = 0;
    instr_t exp_q[$];
    instr_t s_id, s_ex;
    logic fresh = 1'b0;

    branch_commit_unit #(.INDEX_WIDTH(12)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .IF_valid_i(IF_valid_i), .IF_pc_i(IF_pc_i), .IF_btb_hit_i(IF_btb_hit_i),
        .stall_i(stall_i), .flush_i(flush_i),
        .ID_is_br_i(ID_is_br_i), .ID_is_jal_i(ID_is_jal_i), .ID_is_jalr_i(ID_is_jalr_i),
        .ID_funct3_i(ID_funct3_i),
        .EX_rs1_i(EX_rs1_i), .EX_rs2_i(EX_rs2_i), .EX_imm_i(EX_imm_i),
        .EXMEM_btb_wr_index_o(wr_index), .EXMEM_btb_wr_tag_o(wr_tag),
        .EXMEM_btb_wr_target_o(wr_target), .EXMEM_btb_hit_o(btb_hit),
        .EXMEM_br_decision_o(br_dec), .EXMEM_is_jmp_o(is_jmp),
        .EXMEM_pc_plus4_o(pc_plus4)
`ifdef BR_PERF_CNT_EN
        , .perf_br_cnt_o(perf_br_cnt), .perf_mispred_cnt_o(perf_mispred_cnt)
`endif
    );

    always #5 clk = ~clk;

    function automatic instr_t mk(logic v, logic [31:0] pc, logic hit,
                                  logic br, logic jal, logic jalr, logic [2:0] f3,
                                  logic [31:0] rs1, logic [31:0] rs2, logic [31:0] imm,
                                  logic ej, logic ed, logic [31:0] et);
        instr_t t;
        t.v = v; t.pc = pc; t.hit = hit; t.br = br; t.jal = jal; t.jalr = jalr;
        t.f3 = f3; t.rs1 = rs1; t.rs2 = rs2; t.imm = imm;
        t.exp_jmp = ej; t.exp_dec = ed; t.exp_tgt = et;
        return t;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock: drive IF from nxt, ID from s_id, EX from s_ex; advance the shadow pipeline.
    task automatic cycle(input instr_t nxt, input logic st, input logic fl);
        IF_valid_i   = nxt.v;  IF_pc_i = nxt.pc;  IF_btb_hit_i = nxt.hit;
        ID_is_br_i   = s_id.br; ID_is_jal_i = s_id.jal; ID_is_jalr_i = s_id.jalr;
        ID_funct3_i  = s_id.f3;
        EX_rs1_i     = s_ex.rs1; EX_rs2_i = s_ex.rs2; EX_imm_i = s_ex.imm;
        stall_i = st; flush_i = fl;
        if (!fl && !st && s_ex.v && s_ex.exp_jmp) exp_q.push_back(s_ex);
        @(posedge clk);
        if (fl) begin
            s_id.v = 1'b0; s_ex.v = 1'b0;
        end else if (!st) begin
            s_ex = s_id; s_id = nxt;
        end
        @(negedge clk);
    endtask

    // Freshly loaded EX/MEM contents are those after an unstalled edge.
    always @(posedge clk) fresh <= !stall_i;

    // Monitor: pop and compare every fresh commit.
    always @(negedge clk) begin
        if (!rst_i && fresh && is_jmp) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_commit", {wr_target, pc_plus4}, 128'd0);
            end else begin
                instr_t e;
                e = exp_q.pop_front();
                chk("commit_fields",
                    {br_dec, btb_hit, wr_index, wr_tag, wr_target, pc_plus4},
                    {e.exp_dec, e.hit, e.pc[13:2], e.pc[31:14], e.exp_tgt, e.pc + 32'd4});
            end
        end
    end

    instr_t NOP, T1, T2a, T2b, T3, JAL1, BNE1, BGE1, BGEU1, ILL, NONJ, WRAP;
    instr_t F1, F2, F3, P1, S1, S2, J1, J2, J3, J4;
    logic [96:0] snap;
`ifdef BR_PERF_CNT_EN
    logic [31:0] cnt_snap;
`endif

    initial begin
        NOP   = mk(0, 32'h0, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0, 0);
        T1    = mk(1, 32'h100, 0, 1, 0, 0, 3'b000, 5, 5, 32'h20, 1, 1, 32'h120);
        T2a   = mk(1, 32'h200, 0, 1, 0, 0, 3'b100, 32'hFFFF_FFFF, 1, 32'h10, 1, 1, 32'h210);
        T2b   = mk(1, 32'h204, 1, 1, 0, 0, 3'b110, 32'hFFFF_FFFF, 1, 32'hFFFF_FFF8, 1, 0, 32'h1FC);
        T3    = mk(1, 32'h300, 1, 0, 0, 1, 3'b000, 32'h2001, 0, 32'h2, 1, 1, 32'h2002);
        JAL1  = mk(1, 32'h1234_5678, 1, 0, 1, 0, 3'b000, 0, 0, 32'h100, 1, 1, 32'h1234_5778);
        BNE1  = mk(1, 32'h400, 0, 1, 0, 0, 3'b001, 3, 3, 32'h40, 1, 0, 32'h440);
        BGE1  = mk(1, 32'h500, 0, 1, 0, 0, 3'b101, 1, 32'hFFFF_FFFF, 32'h8, 1, 1, 32'h508);
        BGEU1 = mk(1, 32'h504, 1, 1, 0, 0, 3'b111, 1, 32'hFFFF_FFFF, 32'h4, 1, 0, 32'h508);
        ILL   = mk(1, 32'h600, 1, 1, 0, 0, 3'b010, 7, 7, 32'h4, 0, 0, 0);
        NONJ  = mk(1, 32'h700, 1, 0, 0, 0, 3'b000, 0, 0, 32'h4, 0, 0, 0);
        WRAP  = mk(1, 32'hFFFF_FFF0, 0, 0, 1, 0, 3'b000, 0, 0, 32'h20, 1, 1, 32'h10);
        F1    = mk(1, 32'h800, 0, 1, 0, 0, 3'b000, 1, 1, 32'h10, 1, 1, 32'h810);
        F2    = mk(1, 32'h804, 0, 0, 1, 0, 3'b000, 0, 0, 32'h10, 1, 1, 32'h814);
        F3    = mk(1, 32'h808, 0, 0, 1, 0, 3'b000, 0, 0, 32'h10, 1, 1, 32'h818);
        P1    = mk(1, 32'h900, 1, 1, 0, 0, 3'b001, 1, 2, 32'hFFFF_FF00, 1, 1, 32'h800);
        S1    = mk(1, 32'hA00, 0, 1, 0, 0, 3'b000, 9, 9, 32'h30, 1, 1, 32'hA30);
        S2    = mk(1, 32'hA04, 1, 0, 0, 1, 3'b000, 32'h4000, 0, 32'h7, 1, 1, 32'h4006);
        J1    = mk(1, 32'hB00, 0, 0, 1, 0, 3'b000, 0, 0, 32'h40, 1, 1, 32'hB40);
        J2    = mk(1, 32'hB04, 0, 0, 1, 0, 3'b000, 0, 0, 32'h40, 1, 1, 32'hB44);
        J3    = mk(1, 32'hB08, 0, 0, 1, 0, 3'b000, 0, 0, 32'h40, 1, 1, 32'hB48);
        J4    = mk(1, 32'hC00, 1, 0, 1, 0, 3'b000, 0, 0, 32'h8, 1, 1, 32'hC08);
        s_id = NOP; s_ex = NOP;

        rst_i = 1'b1; stall_i = 0; flush_i = 0;
        IF_valid_i = 0; IF_pc_i = 0; IF_btb_hit_i = 0;
        ID_is_br_i = 0; ID_is_jal_i = 0; ID_is_jalr_i = 0; ID_funct3_i = 0;
        EX_rs1_i = 0; EX_rs2_i = 0; EX_imm_i = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs", {is_jmp, br_dec, btb_hit, wr_index, wr_tag, wr_target, pc_plus4}, 128'd0);
        rst_i = 1'b0;

        // Latency: BEQ visible on EXMEM after the third edge, not before.
        cycle(T1, 0, 0);
        cycle(NOP, 0, 0);
        chk("latency_early_is_jmp", is_jmp, 0);
        cycle(NOP, 0, 0);
        chk("latency_n3_is_jmp", is_jmp, 1);
        chk("t1_index_tag", {wr_index, wr_tag}, {12'h040, 18'h0});

        // Back-to-back decision/target vectors.
        cycle(T2a, 0, 0); cycle(T2b, 0, 0); cycle(T3, 0, 0); cycle(JAL1, 0, 0);
        cycle(BNE1, 0, 0); cycle(BGE1, 0, 0); cycle(BGEU1, 0, 0);
        cycle(ILL, 0, 0); cycle(NONJ, 0, 0); cycle(WRAP, 0, 0);
        cycle(NOP, 0, 0);
        chk("nonjump_is_jmp", {is_jmp, br_dec}, 0);
        cycle(NOP, 0, 0);
        cycle(NOP, 0, 0);

        // Flush (with stall also high) kills both younger branches and the IF one.
        cycle(F1, 0, 0);
        cycle(F2, 0, 0);
        cycle(F3, 1, 1);
        chk("flush_c1_is_jmp", {is_jmp, br_dec}, 0);
        cycle(NOP, 0, 0);
        chk("flush_c2_is_jmp", is_jmp, 0);
        cycle(NOP, 0, 0);
        chk("flush_c3_is_jmp", is_jmp, 0);
        cycle(P1, 0, 0); cycle(NOP, 0, 0); cycle(NOP, 0, 0);
        cycle(NOP, 0, 0);

        // Stall with a branch in EX/MEM and another behind it.
        cycle(S1, 0, 0);
        cycle(S2, 0, 0);
        cycle(NOP, 0, 0);
        snap = {is_jmp, br_dec, btb_hit, wr_index, wr_tag, wr_target, pc_plus4};
        chk("stall_pre_is_jmp", is_jmp, 1);
`ifdef BR_PERF_CNT_EN
        cnt_snap = perf_br_cnt;
`endif
        for (int i = 0; i < 4; i++) begin
            cycle(NOP, 1, 0);
            chk("stall_hold", {is_jmp, br_dec, btb_hit, wr_index, wr_tag, wr_target, pc_plus4}, snap);
        end
        cycle(NOP, 0, 0);
`ifdef BR_PERF_CNT_EN
        chk("perf_br_cnt_step", perf_br_cnt, cnt_snap + 32'd1);
`endif
        cycle(NOP, 0, 0);
        cycle(NOP, 0, 0);

        // Asynchronous reset mid-cycle with three jumps in flight.
        cycle(J1, 0, 0); cycle(J2, 0, 0); cycle(J3, 0, 0);
        #2 rst_i = 1'b1;
        #1;
        chk("async_reset_outputs", {is_jmp, br_dec, btb_hit, wr_index, wr_tag, wr_target, pc_plus4}, 128'd0);
        @(posedge clk);
        @(negedge clk);
        rst_i = 1'b0;
        s_id.v = 1'b0; s_ex.v = 1'b0;
        for (int i = 0; i < 4; i++) cycle(NOP, 0, 0);
        chk("post_reset_no_commit", is_jmp, 0);
        cycle(J4, 0, 0); cycle(NOP, 0, 0); cycle(NOP, 0, 0);

        // Drain with a bound.
        for (int i = 0; i < 10 && exp_q.size() != 0; i++) cycle(NOP, 0, 0);
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
